// File: rtl/sound_pkg.sv
// Shared types and constants for the jingle sequencer: note codes, jingle and FSM enums,
// the ROM entry layout and a small constructor for ROM entries.
package sound_pkg;

    localparam int DUR_W = 10;

    localparam logic [7:0] NOTE_A    = 8'd89;
    localparam logic [7:0] NOTE_DS   = 8'd126;
    localparam logic [7:0] NOTE_C    = 8'd149;
    localparam logic [7:0] NOTE_REST = 8'd0;

    // Encoding order doubles as arbitration priority (higher value wins).
    typedef enum logic [1:0] {
        J_START = 2'd0,
        J_EAT   = 2'd1,
        J_OVER  = 2'd2
    } jingle_t;

    typedef struct packed {
        logic [7:0]       code;
        logic [DUR_W-1:0] dur;
        logic             last;
    } note_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic note_t mkNote(logic [7:0] c, int d, logic l);
        note_t n;
        n.code = c;
        n.dur  = DUR_W'(d);
        n.last = l;
        return n;
    endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Game-control and oscillator-facing signals of the sequencer, bundled as one interface.
interface sound_sequencer_if;
    logic       evt_start;
    logic       evt_eat;
    logic       evt_over;
    logic       mute;
    logic [7:0] freq;
    logic       playSound;
    logic       busy;
    logic       done;

    modport master (
        output evt_start, evt_eat, evt_over, mute,
        input  freq, playSound, busy, done
    );

    modport slave (
        input  evt_start, evt_eat, evt_over, mute,
        output freq, playSound, busy, done
    );
endinterface

// File: rtl/sound_rom.sv
// Fixed note table: combinational lookup of (jingle, note index) to code/duration/last flag.
module sound_rom
    import sound_pkg::*;
(
    input  jingle_t    jingle_i,
    input  logic [1:0] idx_i,
    output note_t      note_o
);

    // Unused slots decode as a one-tick last rest so a stray index can never hang the FSM.
    always_comb begin
        note_o = mkNote(NOTE_REST, 1, 1'b1);
        unique case (jingle_i)
            J_START: begin
                case (idx_i)
                    2'd0:    note_o = mkNote(NOTE_C,  100, 1'b0);
                    2'd1:    note_o = mkNote(NOTE_DS, 100, 1'b0);
                    2'd2:    note_o = mkNote(NOTE_A,  100, 1'b1);
                    default: note_o = mkNote(NOTE_REST, 1, 1'b1);
                endcase
            end
            J_EAT: begin
                case (idx_i)
                    2'd0:    note_o = mkNote(NOTE_C, 50, 1'b0);
                    2'd1:    note_o = mkNote(NOTE_A, 50, 1'b1);
                    default: note_o = mkNote(NOTE_REST, 1, 1'b1);
                endcase
            end
            J_OVER: begin
                case (idx_i)
                    2'd0:    note_o = mkNote(NOTE_A,    150, 1'b0);
                    2'd1:    note_o = mkNote(NOTE_REST,  50, 1'b0);
                    2'd2:    note_o = mkNote(NOTE_DS,   150, 1'b0);
                    default: note_o = mkNote(NOTE_C,    300, 1'b1);
                endcase
            end
            default: note_o = mkNote(NOTE_REST, 1, 1'b1);
        endcase
    end

endmodule

// File: rtl/sound_sequencer.sv
// Jingle sequencer: arbitrates game event pulses, walks the note table and drives the
// tone oscillator with registered freq/playSound plus busy/done status.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int TICK_CYCLES = 10000,
    parameter int GAP_TICKS   = 1
) (
    input logic               clk,
    input logic               rst,
    sound_sequencer_if.slave  bus
);

    localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    state_t             state_q, state_d;
    jingle_t            jingle_q, jingle_d;
    logic [1:0]         idx_q, idx_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUR_W-1:0]   ticks_q, ticks_d;
    note_t              note_q;
    note_t              romNote;

    logic [7:0] freq_q;
    logic       playSound_q;
    logic       busy_q;
    logic       done_q;

    logic       reqValid;
    jingle_t    reqJingle;
    logic       accept;
    logic       tick;
    logic       enter;
    logic [DUR_W-1:0] ticksInc;

    // The ROM is addressed with next-state values so outputs can be registered with 1-cycle latency.
    sound_rom uRom (
        .jingle_i (jingle_d),
        .idx_i    (idx_d),
        .note_o   (romNote)
    );

    always_comb begin
        reqValid  = bus.evt_start | bus.evt_eat | bus.evt_over;
        reqJingle = bus.evt_over ? J_OVER : (bus.evt_eat ? J_EAT : J_START);
        accept    = reqValid &&
                    ((state_q == IDLE) || (state_q == DONE) || (reqJingle >= jingle_q));
        tick      = (presc_q == PRESC_W'(TICK_CYCLES - 1));
        ticksInc  = ticks_q + DUR_W'(1);

        state_d  = state_q;
        jingle_d = jingle_q;
        idx_d    = idx_q;
        enter    = 1'b0;

        if (accept) begin
            state_d  = NOTE;
            jingle_d = reqJingle;
            idx_d    = 2'd0;
            enter    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: ;
                NOTE: begin
                    if (tick && (ticksInc == note_q.dur)) begin
                        enter = 1'b1;
                        if (note_q.last) begin
                            state_d = DONE;
                        end else if (GAP_TICKS == 0) begin
                            idx_d = idx_q + 2'd1;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end
                GAP: begin
                    if (tick && (ticksInc == DUR_W'(GAP_TICKS))) begin
                        state_d = NOTE;
                        idx_d   = idx_q + 2'd1;
                        enter   = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    enter   = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    enter   = 1'b1;
                end
            endcase
        end

        // Counters restart on every state entry and stay parked outside NOTE/GAP.
        if (enter || (state_q == IDLE) || (state_q == DONE)) begin
            presc_d = '0;
            ticks_d = '0;
        end else if (tick) begin
            presc_d = '0;
            ticks_d = ticksInc;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
            ticks_d = ticks_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            jingle_q    <= J_START;
            idx_q       <= '0;
            presc_q     <= '0;
            ticks_q     <= '0;
            note_q      <= '0;
            freq_q      <= '0;
            playSound_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            jingle_q    <= jingle_d;
            idx_q       <= idx_d;
            presc_q     <= presc_d;
            ticks_q     <= ticks_d;
            note_q      <= romNote;
            freq_q      <= (state_d == NOTE) ? romNote.code : 8'd0;
            playSound_q <= (state_d == NOTE) && (romNote.code != 8'd0) && !bus.mute;
            busy_q      <= (state_d == NOTE) || (state_d == GAP);
            done_q      <= (state_d == DONE);
        end
    end

    assign bus.freq      = freq_q;
    assign bus.playSound = playSound_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
